// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder controller: FSM state width and encodings.
package serial_add_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] IDLE  = 2'd0;
    localparam logic [ST_W-1:0] SHIFT = 2'd1;
    localparam logic [ST_W-1:0] DONE  = 2'd2;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational 1-bit full adder cell used as the serial adder's only arithmetic element.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ cin;
    assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first, one bit per clock.
// Optional macro SERIAL_ADD_OVF_EN adds a signed-overflow output (ovf).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [ST_W-1:0]  state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Only WIDTH-1 partial bits are stored; the final bit comes straight from the cell.
    logic [WIDTH-2:0] s_sh_q, s_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sum_next;

    fa_cell u_fa (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .c   (fa_c)
    );

    assign sum_next = {fa_s, s_sh_q};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts a new start exactly like IDLE so ops can run back to back.
                state_d = IDLE;
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    s_sh_d  = '0;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                s_sh_d  = sum_next[WIDTH-1:1];
                carry_d = fa_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = sum_next;
                    cout_d  = fa_c;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q is the carry into the MSB on this final cycle.
                    ovf_d   = fa_c ^ carry_q;
`endif
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [WIDTH:0] exp_q[$];
    logic           exp_ovf_q[$];

    logic [WIDTH-1:0] last_sum;
    logic             last_cout;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

`ifndef SERIAL_ADD_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    // Reference: plain unsigned integer addition.
    function automatic logic [WIDTH:0] model_sum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                 input logic ci);
        int r;
        r = int'(x) + int'(y) + int'(ci);
        return (WIDTH+1)'(r);
    endfunction

    // Reference: signed result out of the representable two's-complement range.
    function automatic logic model_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                       input logic ci);
        int sx, sy, r;
        sx = (int'(x) >= 128) ? int'(x) - 256 : int'(x);
        sy = (int'(y) >= 128) ? int'(y) - 256 : int'(y);
        r  = sx + sy + int'(ci);
        return (r > 127) || (r < -128);
    endfunction

    // Drives one operation and reports what was observed; the callers judge it.
    task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b, input logic op_c,
                          input int gap, input int poke_at,
                          output int lat, output int busy_cycles, output int held_err,
                          output logic [WIDTH-1:0] s_o, output logic c_o, output logic v_o);
        repeat (gap) @(negedge clk);
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        cin   = op_c;
        lat = 0; busy_cycles = 0; held_err = 0;
        s_o = '0; c_o = 1'b0; v_o = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cycles++;
            if (done) begin
                s_o = sum; c_o = cout; v_o = ovf;
                break;
            end
            if (sum !== last_sum || cout !== last_cout) held_err++;
            start = (lat == poke_at);
            if (lat == poke_at) begin
                a = 8'h11; b = 8'h22;
            end else begin
                a = WIDTH'($urandom); b = WIDTH'($urandom);
            end
            cin = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({busy, done, cout, ovf} !== 4'b0000) $display("FAIL reset_flags: busy/done/cout/ovf=%b want 0000", {busy, done, cout, ovf});
        else pass_cnt++;
        total_cnt++;
        if (sum !== '0) $display("FAIL reset_sum: got %h want 00", sum);
        else pass_cnt++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({busy, done} !== 2'b00) $display("FAIL post_reset_idle: busy/done=%b want 00", {busy, done});
        else pass_cnt++;
        last_sum = '0; last_cout = 1'b0;
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] ta[5] = '{8'h35, 8'hFF, 8'h00, 8'h7F, 8'hFF};
        logic [WIDTH-1:0] tb[5] = '{8'h4A, 8'h01, 8'h00, 8'h01, 8'h01};
        logic             tc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int lat, bc, he;
        logic [WIDTH-1:0] s; logic c, v;
        logic [WIDTH:0] e; logic ev;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(model_sum(ta[i], tb[i], tc[i]));
            exp_ovf_q.push_back(model_ovf(ta[i], tb[i], tc[i]));
            run_op(ta[i], tb[i], tc[i], 2, -1, lat, bc, he, s, c, v);
            e = exp_q.pop_front(); ev = exp_ovf_q.pop_front();
            total_cnt++;
            if (lat !== 9) $display("FAIL dir%0d_latency: got %0d want 9", i, lat);
            else pass_cnt++;
            total_cnt++;
            if (bc !== 8) $display("FAIL dir%0d_busy_cycles: got %0d want 8", i, bc);
            else pass_cnt++;
            total_cnt++;
            if (he !== 0) $display("FAIL dir%0d_held: %0d cycles sum moved, want 0", i, he);
            else pass_cnt++;
            total_cnt++;
            if ({c, s} !== e) $display("FAIL dir%0d_result: cout,sum=%h want %h", i, {c, s}, e);
            else pass_cnt++;
`ifdef SERIAL_ADD_OVF_EN
            total_cnt++;
            if (v !== ev) $display("FAIL dir%0d_ovf: got %b want %b", i, v, ev);
            else pass_cnt++;
`endif
            last_sum = e[WIDTH-1:0]; last_cout = e[WIDTH];
        end
    endtask

    task automatic test_random();
        int lat, bc, he;
        logic [WIDTH-1:0] s, ra, rb; logic c, v, rc;
        logic [WIDTH:0] e; logic ev;
        for (int i = 0; i < 16; i++) begin
            ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom_range(0, 1));
            exp_q.push_back(model_sum(ra, rb, rc));
            exp_ovf_q.push_back(model_ovf(ra, rb, rc));
            run_op(ra, rb, rc, $urandom_range(0, 2), -1, lat, bc, he, s, c, v);
            e = exp_q.pop_front(); ev = exp_ovf_q.pop_front();
            total_cnt++;
            if (lat !== 9 || bc !== 8 || he !== 0)
                $display("FAIL rnd%0d_timing: lat=%0d busy=%0d held_err=%0d want 9/8/0", i, lat, bc, he);
            else pass_cnt++;
            total_cnt++;
            if ({c, s} !== e) $display("FAIL rnd%0d_result: a=%h b=%h cin=%b got %h want %h", i, ra, rb, rc, {c, s}, e);
            else pass_cnt++;
`ifdef SERIAL_ADD_OVF_EN
            total_cnt++;
            if (v !== ev) $display("FAIL rnd%0d_ovf: got %b want %b", i, v, ev);
            else pass_cnt++;
`endif
            last_sum = e[WIDTH-1:0]; last_cout = e[WIDTH];
        end
    endtask

    task automatic test_start_ignored();
        int lat, bc, he, extra_done;
        logic [WIDTH-1:0] s; logic c, v;
        logic [WIDTH:0] e;
        exp_q.push_back(model_sum(8'h35, 8'h4A, 1'b0));
        run_op(8'h35, 8'h4A, 1'b0, 2, 3, lat, bc, he, s, c, v);
        e = exp_q.pop_front();
        total_cnt++;
        if (lat !== 9 || bc !== 8) $display("FAIL ignore_timing: lat=%0d busy=%0d want 9/8", lat, bc);
        else pass_cnt++;
        total_cnt++;
        if ({c, s} !== e) $display("FAIL ignore_result: got %h want %h", {c, s}, e);
        else pass_cnt++;
        last_sum = e[WIDTH-1:0]; last_cout = e[WIDTH];
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        total_cnt++;
        if (extra_done !== 0) $display("FAIL ignore_no_second_op: %0d active cycles, want 0", extra_done);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] ta[3] = '{8'h35, 8'h10, 8'hC3};
        logic [WIDTH-1:0] tb[3] = '{8'h4A, 8'h20, 8'h9E};
        int lat, bc, he;
        logic [WIDTH-1:0] s; logic c, v;
        logic [WIDTH:0] e;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(model_sum(ta[i], tb[i], 1'b0));
            run_op(ta[i], tb[i], 1'b0, (i == 0) ? 2 : 0, -1, lat, bc, he, s, c, v);
            e = exp_q.pop_front();
            total_cnt++;
            if (lat !== 9 || bc !== 8 || he !== 0)
                $display("FAIL b2b%0d_timing: lat=%0d busy=%0d held_err=%0d want 9/8/0", i, lat, bc, he);
            else pass_cnt++;
            total_cnt++;
            if ({c, s} !== e) $display("FAIL b2b%0d_result: got %h want %h", i, {c, s}, e);
            else pass_cnt++;
            last_sum = e[WIDTH-1:0]; last_cout = e[WIDTH];
        end
    endtask

    task automatic test_reset_mid_op();
        int active;
        @(negedge clk);
        start = 1'b1; a = 8'hA5; b = 8'h3C; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({busy, done, cout, ovf} !== 4'b0000) $display("FAIL midrst_flags: busy/done/cout/ovf=%b want 0000", {busy, done, cout, ovf});
        else pass_cnt++;
        total_cnt++;
        if (sum !== '0) $display("FAIL midrst_sum: got %h want 00", sum);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        active = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) active++;
        end
        total_cnt++;
        if (active !== 0) $display("FAIL midrst_no_done: %0d active cycles, want 0", active);
        else pass_cnt++;
        last_sum = '0; last_cout = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_op();
        test_directed();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: one 1-bit full-adder cell plus a carry flip-flop add two WIDTH-bit operands, LSB first, one bit per clock.
- Accepts a start/operand handshake, sequences WIDTH add cycles, then presents sum/carry with a one-cycle done pulse.
- Serves as the area-minimal adder engine for multi-bit arithmetic built from the team's full-adder cell.

Parameters:
WIDTH, 8, operand/sum width in bits (legal range 2..32)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  operand A, captured on the accepted start
b  input  WIDTH  operand B, captured on the accepted start
cin  input  1  carry-in, captured on the accepted start
busy  output  1  high while bits are being shifted
done  output  1  one-cycle pulse when sum/cout become valid
sum  output  WIDTH  result; held stable until the next accepted start completes
cout  output  1  final carry-out; held with sum

Behaviour:
- Reset (async assert, released synchronously by the clock domain): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, counter and carry FF cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge k -> latch a, b into shift regs, carry FF<=cin, counter<=0, go to SHIFT; busy=1 from edge k.
- SHIFT: each edge, full-adder cell computes s,c from shift-reg LSBs and carry FF. s shifts into the MSB of the sum shift reg (right shift). Carry FF<=c. Counter increments.
- When the counter reaches WIDTH-1 and that bit is processed (edge k+WIDTH): sum/cout registered, go to DONE; busy=0, done=1.
- Latency: accepted start at edge k -> done high for exactly the cycle after edge k+WIDTH.
- DONE: lasts one cycle, then IDLE. start=1 during DONE is accepted like IDLE (back-to-back ops, no bubble); done still drops after one cycle.
- start while busy=1: ignored, no effect on the operation in flight; operand inputs are don't-care after capture.
- Arithmetic: unsigned; {cout,sum} = a + b + cin exactly, modulo 2^(WIDTH+1).
- sum/cout update only at the transition into DONE; intermediate partial sums never appear on sum.
- Reset mid-operation: immediate abort, all outputs return to reset values, no done pulse.
- Carry chain: carry FF is the only carry storage; no combinational path from a/b/cin to any output.

Optional Feature:
- Macro SERIAL_ADD_OVF_EN.
- Defined: extra output port ovf (1 bit) = signed two's-complement overflow. It equals carry into MSB XOR carry out of MSB, captured on the final SHIFT cycle. It updates and holds with sum and resets to 0.
- Undefined: no ovf port and no extra logic; all other behaviour identical.

Decomposition:
- Package serial_add_pkg: state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the state width constant.
- One natural sub-module: fa_cell (combinational 1-bit full adder: a, b, cin -> s, c), instantiated once.
- Controller FSM, counter, shift registers and carry FF stay in serial_add_ctrl.

Test Plan:
1. WIDTH=8, a=0x35, b=0x4A, cin=0, start pulse -> done pulses exactly 9 cycles after start is sampled (edge k+8); sum=0x7F, cout=0; busy high 8 cycles.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
3. start re-asserted at cycle 3 of an op with a=0x11, b=0x22 -> ignored; original result sum/cout unchanged; no second done.
4. start held high during DONE with a=0x10, b=0x20 -> new op begins immediately; second done 8 cycles later with sum=0x30; first result held until then.
5. rst asserted at cycle 4 of an op -> busy, done, sum, cout go to 0 asynchronously; no done after release until a new start.
6. With SERIAL_ADD_OVF_EN: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Then a=0xFF, b=0x01 -> sum=0x00, cout=1, ovf=0.
